// File: rtl/tcdm_xbar_pkg.sv
// rtl/tcdm_xbar_pkg.sv - shared helpers for the TCDM logarithmic crossbar
// Contents: idx_width() returns an index width that stays at least one bit wide.
package tcdm_xbar_pkg;

   // Width of an index into n entries; a single-entry range still gets one bit
   // so that pointer and select registers remain legal vectors.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tcdm_xbar_rr_arb.sv
// rtl/tcdm_xbar_rr_arb.sv - per-bank round-robin arbiter with payload mux
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_i        : one request bit per master
//   data_i       : packed payload per master
//   gnt_o        : one-hot grant (all zero when idle)
//   valid_o      : any request present (bank chip select)
//   data_o       : payload of the granted master, zero when idle
module tcdm_xbar_rr_arb
   import tcdm_xbar_pkg::*;
#(
   parameter int unsigned NumReq    = 4,
   parameter int unsigned DataWidth = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NumReq-1:0]    req_i,
   input  logic [DataWidth-1:0] data_i [NumReq],
   output logic [NumReq-1:0]    gnt_o,
   output logic                 valid_o,
   output logic [DataWidth-1:0] data_o
);

   localparam int unsigned PtrW = idx_width(NumReq);

   logic [PtrW-1:0] ptr_q;
   logic [PtrW-1:0] win;
   logic            found;

   // Search starts at the pointer and wraps; the first requester found wins.
   always_comb begin : search
      int unsigned     idx;
      logic [PtrW-1:0] cand;
      idx   = 0;
      cand  = '0;
      win   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         idx = 32'(ptr_q) + i;
         if (idx >= NumReq) begin
            idx = idx - NumReq;
         end
         cand = PtrW'(idx);
         if (!found && req_i[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      gnt_o   = '0;
      data_o  = '0;
      valid_o = found;
      if (found) begin
         gnt_o[win] = 1'b1;
         data_o     = data_i[win];
      end
   end

   // Winner moves to lowest priority; an idle bank keeps its pointer.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else if (found) begin
         ptr_q <= (32'(win) == NumReq - 1) ? '0 : win + PtrW'(1);
      end
   end

endmodule

// File: rtl/tcdm_xbar.sv
// rtl/tcdm_xbar.sv - single-cycle logarithmic crossbar from masters to interleaved TCDM banks
// Ports:
//   clk_i, rst_i                       : clock, synchronous active-high reset
//   req_i/add_i/wen_i/wdata_i/be_i     : master requests (byte address, 1 = load)
//   gnt_o                              : combinational grant per master
//   rvld_o/rdata_o                     : response one cycle after grant
//   cs_o/add_o/wen_o/wdata_o/be_o      : bank request (word address), zero when idle
//   rdata_i                            : bank read data, one cycle after cs_o
module tcdm_xbar
   import tcdm_xbar_pkg::*;
#(
   parameter int unsigned NumMaster    = 4,
   parameter int unsigned NumSlave     = 8,
   parameter int unsigned AddrWidth    = 32,
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned BeWidth      = DataWidth / 8,
   parameter int unsigned AddrMemWidth = 12
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NumMaster-1:0]    req_i,
   input  logic [AddrWidth-1:0]    add_i   [NumMaster],
   input  logic [NumMaster-1:0]    wen_i,
   input  logic [DataWidth-1:0]    wdata_i [NumMaster],
   input  logic [BeWidth-1:0]      be_i    [NumMaster],
   output logic [NumMaster-1:0]    gnt_o,
   output logic [NumMaster-1:0]    rvld_o,
   output logic [DataWidth-1:0]    rdata_o [NumMaster],
   output logic [NumSlave-1:0]     cs_o,
   output logic [AddrMemWidth-1:0] add_o   [NumSlave],
   output logic [NumSlave-1:0]     wen_o,
   output logic [DataWidth-1:0]    wdata_o [NumSlave],
   output logic [BeWidth-1:0]      be_o    [NumSlave],
   input  logic [DataWidth-1:0]    rdata_i [NumSlave]
);

   localparam int unsigned AddrWordOff = $clog2(DataWidth / 8);
   localparam int unsigned SelW        = idx_width(NumSlave);
   localparam int unsigned PayW        = AddrMemWidth + 1 + BeWidth + DataWidth;

   if (AddrWordOff + SelW + AddrMemWidth > AddrWidth) begin : g_addr_check
      $error("tcdm_xbar: AddrWidth too small for bank select plus bank address");
   end

   logic [NumMaster-1:0]    req_act;
   logic [SelW-1:0]         sel      [NumMaster];
   logic [AddrMemWidth-1:0] bank_add [NumMaster];
   logic [PayW-1:0]         pay      [NumMaster];
   logic [NumMaster-1:0]    bank_req [NumSlave];
   logic [NumMaster-1:0]    bank_gnt [NumSlave];
   logic [PayW-1:0]         bank_pay [NumSlave];
   logic [NumMaster-1:0]    rvld_q;
   logic [SelW-1:0]         sel_q    [NumMaster];
   logic [NumMaster-1:0]    unused_add;

   // Requests are masked during reset so nothing pending is granted or answered.
   assign req_act = rst_i ? '0 : req_i;

   for (genvar j = 0; j < NumMaster; j++) begin : g_master
      assign sel[j]        = add_i[j][AddrWordOff +: SelW];
      assign bank_add[j]   = add_i[j][AddrWordOff + SelW +: AddrMemWidth];
      assign pay[j]        = {bank_add[j], wen_i[j], be_i[j], wdata_i[j]};
      // Byte-offset and upper address bits are intentionally ignored.
      assign unused_add[j] = ^add_i[j];
   end

   always_comb begin
      for (int k = 0; k < NumSlave; k++) begin
         for (int j = 0; j < NumMaster; j++) begin
            bank_req[k][j] = req_act[j] && (sel[j] == SelW'(k));
         end
      end
   end

   for (genvar k = 0; k < NumSlave; k++) begin : g_bank
      tcdm_xbar_rr_arb #(
         .NumReq    (NumMaster),
         .DataWidth (PayW)
      ) u_arb (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .req_i   (bank_req[k]),
         .data_i  (pay),
         .gnt_o   (bank_gnt[k]),
         .valid_o (cs_o[k]),
         .data_o  (bank_pay[k])
      );
      assign {add_o[k], wen_o[k], be_o[k], wdata_o[k]} = bank_pay[k];
   end

   // Only the bank a master addresses can grant it.
   always_comb begin
      gnt_o = '0;
      for (int j = 0; j < NumMaster; j++) begin
         gnt_o[j] = bank_gnt[sel[j]][j];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rvld_q <= '0;
         for (int j = 0; j < NumMaster; j++) begin
            sel_q[j] <= '0;
         end
      end else begin
         rvld_q <= gnt_o;
         for (int j = 0; j < NumMaster; j++) begin
            if (gnt_o[j]) begin
               sel_q[j] <= sel[j];
            end
         end
      end
   end

   assign rvld_o = rvld_q;

   always_comb begin
      for (int j = 0; j < NumMaster; j++) begin
         rdata_o[j] = rdata_i[sel_q[j]];
      end
   end

endmodule

// File: tb/tb_tcdm_xbar.sv
// tb/tb_tcdm_xbar.sv - self-checking bench for tcdm_xbar
module tb_tcdm_xbar;

   localparam int NM = 4;
   localparam int NS = 8;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = 4;
   localparam int MW = 12;
   localparam int PW = MW + 1 + BW + DW;

   logic          clk = 1'b0;
   logic          rst;
   logic [NM-1:0] req, wen, gnt, rvld;
   logic [AW-1:0] add     [NM];
   logic [DW-1:0] wdata   [NM];
   logic [BW-1:0] be      [NM];
   logic [DW-1:0] rdata_o [NM];
   logic [NS-1:0] cs, wen_o;
   logic [MW-1:0] add_o   [NS];
   logic [DW-1:0] wdata_o [NS];
   logic [DW-1:0] rdata_i [NS];
   logic [BW-1:0] be_o    [NS];

   tcdm_xbar dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .req_i   (req),
      .add_i   (add),
      .wen_i   (wen),
      .wdata_i (wdata),
      .be_i    (be),
      .gnt_o   (gnt),
      .rvld_o  (rvld),
      .rdata_o (rdata_o),
      .cs_o    (cs),
      .add_o   (add_o),
      .wen_o   (wen_o),
      .wdata_o (wdata_o),
      .be_o    (be_o),
      .rdata_i (rdata_i)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int            ptr      [NS];
   int            last_sel [NM];
   int            exp_win  [NS];
   logic [NM-1:0] prev_gnt, exp_gnt;
   logic [NS-1:0] exp_cs;
   logic [PW-1:0] exp_pay  [NS];

   typedef struct {
      logic                 rst;
      logic [NM-1:0]        req;
      logic [NM-1:0]        wen;
      logic [NM-1:0][AW-1:0] add;
      logic [NM-1:0][BW-1:0] be;
      logic [NM-1:0][DW-1:0] wd;
      logic [NM-1:0]        gnt;
      logic [NS-1:0]        cs;
      logic [NM-1:0]        rvld;
   } vec_t;

   vec_t vecs[$];
   int   cnt [NM];

   function automatic int bank_of(input logic [AW-1:0] a);
      return int'((a / 4) % 8);
   endfunction

   function automatic logic [MW-1:0] word_of(input logic [AW-1:0] a);
      return MW'((a / 32) % 4096);
   endfunction

   function automatic vec_t mk(input logic r, input logic [NM-1:0] rq, input logic [NM-1:0] w,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                               input logic [NM-1:0] g, input logic [NS-1:0] c,
                               input logic [NM-1:0] v);
      vec_t t;
      t.rst = r; t.req = rq; t.wen = w;
      t.add[0] = a0; t.add[1] = a1; t.add[2] = a2; t.add[3] = a3;
      for (int j = 0; j < NM; j++) begin
         t.be[j] = 4'hF;
         t.wd[j] = '0;
      end
      t.gnt = g; t.cs = c; t.rvld = v;
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, want);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NS; k++) ptr[k] = 0;
      for (int j = 0; j < NM; j++) last_sel[j] = 0;
      prev_gnt = '0;
   endtask

   // Winner = requester with the smallest cyclic distance from the bank pointer.
   task automatic model_eval();
      exp_gnt = '0;
      exp_cs  = '0;
      for (int k = 0; k < NS; k++) begin
         int best;
         int bestd;
         best = -1;
         bestd = NM;
         exp_pay[k] = '0;
         exp_win[k] = 0;
         if (!rst) begin
            for (int j = 0; j < NM; j++) begin
               if (req[j] && bank_of(add[j]) == k) begin
                  int d;
                  d = (j - ptr[k] + NM) % NM;
                  if (d < bestd) begin
                     bestd = d;
                     best  = j;
                  end
               end
            end
         end
         if (best >= 0) begin
            exp_cs[k]     = 1'b1;
            exp_gnt[best] = 1'b1;
            exp_win[k]    = best;
            exp_pay[k]    = {word_of(add[best]), wen[best], be[best], wdata[best]};
         end
      end
   endtask

   task automatic model_commit();
      if (rst) begin
         model_reset();
      end else begin
         for (int k = 0; k < NS; k++) if (exp_cs[k]) ptr[k] = (exp_win[k] + 1) % NM;
         for (int j = 0; j < NM; j++) if (exp_gnt[j]) last_sel[j] = bank_of(add[j]);
         prev_gnt = exp_gnt;
      end
   endtask

   task automatic sample_and_check();
      #2;
      model_eval();
      chk("gnt", 64'(gnt), 64'(exp_gnt));
      chk("cs", 64'(cs), 64'(exp_cs));
      chk("rvld", 64'(rvld), 64'(prev_gnt));
      for (int k = 0; k < NS; k++) begin
         chk($sformatf("bank%0d_payload", k), 64'({add_o[k], wen_o[k], be_o[k], wdata_o[k]}),
             64'(exp_pay[k]));
      end
      for (int j = 0; j < NM; j++) begin
         if (prev_gnt[j]) chk($sformatf("rdata%0d", j), 64'(rdata_o[j]), 64'(rdata_i[last_sel[j]]));
      end
   endtask

   task automatic advance();
      @(posedge clk);
      model_commit();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      wen = '0;
      for (int j = 0; j < NM; j++) begin
         add[j] = '0; wdata[j] = '0; be[j] = '0;
      end
      for (int k = 0; k < NS; k++) rdata_i[k] = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);

      // rst, req, wen, add0..3, gnt, cs, rvld
      vecs.push_back(mk(1, 4'b0000, 4'b1111, 'h00, 'h00, 'h00, 'h00, 4'b0000, 8'h00, 4'b0000));
      vecs.push_back(mk(0, 4'b0001, 4'b1111, 'h24, 'h00, 'h00, 'h00, 4'b0001, 8'h02, 4'b0000));
      vecs.push_back(mk(0, 4'b1111, 4'b1111, 'h00, 'h04, 'h08, 'h0C, 4'b1111, 8'h0F, 4'b0001));
      vecs.push_back(mk(1, 4'b0111, 4'b1111, 'h0C, 'h0C, 'h0C, 'h0C, 4'b0000, 8'h00, 4'b1111));
      vecs.push_back(mk(0, 4'b0111, 4'b1111, 'h0C, 'h0C, 'h0C, 'h0C, 4'b0001, 8'h08, 4'b0000));
      vecs.push_back(mk(0, 4'b0111, 4'b1111, 'h0C, 'h0C, 'h0C, 'h0C, 4'b0010, 8'h08, 4'b0001));
      vecs.push_back(mk(0, 4'b0111, 4'b1111, 'h0C, 'h0C, 'h0C, 'h0C, 4'b0100, 8'h08, 4'b0010));
      vecs.push_back(mk(0, 4'b0111, 4'b1111, 'h0C, 'h0C, 'h0C, 'h0C, 4'b0001, 8'h08, 4'b0100));
      vecs.push_back(mk(0, 4'b0111, 4'b1111, 'h0C, 'h0C, 'h0C, 'h0C, 4'b0010, 8'h08, 4'b0001));
      vecs.push_back(mk(1, 4'b0011, 4'b1111, 'h0C, 'h0C, 'h00, 'h00, 4'b0000, 8'h00, 4'b0010));
      vecs.push_back(mk(0, 4'b0011, 4'b1111, 'h0C, 'h0C, 'h00, 'h00, 4'b0001, 8'h08, 4'b0000));
      vecs.push_back(mk(0, 4'b0100, 4'b1011, 'h00, 'h00, 'h1_0014, 'h00, 4'b0100, 8'h20, 4'b0001));
      vecs[$].be[2] = 4'b0101;
      vecs[$].wd[2] = 32'h12345678;
      vecs.push_back(mk(0, 4'b0000, 4'b1111, 'h00, 'h00, 'h00, 'h00, 4'b0000, 8'h00, 4'b0100));

      foreach (vecs[i]) begin
         rst = vecs[i].rst;
         req = vecs[i].req;
         wen = vecs[i].wen;
         for (int j = 0; j < NM; j++) begin
            add[j]   = vecs[i].add[j];
            be[j]    = vecs[i].be[j];
            wdata[j] = vecs[i].wd[j];
         end
         for (int k = 0; k < NS; k++) rdata_i[k] = 32'hCAFE0000 + 32'(k);
         sample_and_check();
         chk($sformatf("vec%0d_gnt", i), 64'(gnt), 64'(vecs[i].gnt));
         chk($sformatf("vec%0d_cs", i), 64'(cs), 64'(vecs[i].cs));
         chk($sformatf("vec%0d_rvld", i), 64'(rvld), 64'(vecs[i].rvld));
         if (i == 11) begin
            chk("store_add_o5", 64'(add_o[5]), 64'h800);
            chk("store_be_o5", 64'(be_o[5]), 64'b0101);
            chk("store_wdata_o5", 64'(wdata_o[5]), 64'h12345678);
            chk("store_wen_o5", 64'(wen_o[5]), 64'b0);
         end
         if (i == 2) chk("load_rdata0", 64'(rdata_o[0]), 64'hCAFE0001);
         advance();
      end

      // Fairness: four masters contending for bank 2 for eight cycles.
      rst = 1'b1;
      req = '0;
      sample_and_check();
      advance();
      rst = 1'b0;
      req = 4'b1111;
      for (int j = 0; j < NM; j++) begin
         add[j] = 32'h8;
         cnt[j] = 0;
      end
      for (int c = 0; c < 8; c++) begin
         sample_and_check();
         for (int j = 0; j < NM; j++) cnt[j] += int'(gnt[j]);
         advance();
      end
      for (int j = 0; j < NM; j++) chk($sformatf("fair_cnt%0d", j), 64'(cnt[j]), 64'd2);

      // Randomized traffic against the reference model.
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 39) == 0);
         req = NM'($urandom);
         wen = NM'($urandom);
         for (int j = 0; j < NM; j++) begin
            add[j]   = $urandom;
            be[j]    = BW'($urandom);
            wdata[j] = $urandom;
         end
         for (int k = 0; k < NS; k++) rdata_i[k] = $urandom;
         sample_and_check();
         advance();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
